// File: rtl/hazard_pkg.sv
// Shared hazard encodings and slot/record layout helpers for the HDU, the event
// queue and the display/trace logic.
package hazard_pkg;

  typedef enum logic [1:0] {
    HZ_NONE = 2'b00,
    HZ_RAW  = 2'b01,
    HZ_WAR  = 2'b10,
    HZ_WAW  = 2'b11
  } hz_kind_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  localparam int KIND_W        = 2;
  localparam int SLOT_KIND_LSB = 0;
  localparam int REC_KIND_LSB  = 0;
  localparam int REC_RS_LSB    = KIND_W;

  // Slot fields are packed from the MSB down; any spare bits sit just above kind.
  function automatic int slot_rd_lsb(input int slot_w, input int reg_w);
    return slot_w - reg_w;
  endfunction

  function automatic int slot_rs_lsb(input int slot_w, input int reg_w);
    return slot_w - 2 * reg_w;
  endfunction

  function automatic int rec_rd_lsb(input int reg_w);
    return KIND_W + reg_w;
  endfunction

  function automatic int rec_idx_lsb(input int reg_w);
    return KIND_W + 2 * reg_w;
  endfunction

endpackage

// File: rtl/hz_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a pop frees room for a push in the
// same cycle, so a full FIFO can accept while draining.
module hz_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign count = wr_ptr_r - rd_ptr_r;
  assign rdata = mem_r[rd_ptr_r[AW-1:0]];

  // Accept/consume qualification
  always_comb begin
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
  end

  // Pointer update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

  // Storage write; contents are only observed behind the pointers
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/hazard_event_queue.sv
// Captures a hazard slot vector, scans one slot per cycle and queues every
// non-empty slot as {slot_idx, rd, rs, kind}, with saturating statistics.
module hazard_event_queue
  import hazard_pkg::*;
#(
  parameter int REG_W   = 3,
  parameter int N_SLOTS = 13,
  parameter int SLOT_W  = 8,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16,
  localparam int IDX_W  = $clog2(N_SLOTS),
  localparam int REC_W  = IDX_W + 2*REG_W + KIND_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_SLOTS*SLOT_W-1:0] hz_vec,
  input  logic                      hz_valid,
  output logic                      hz_ready,
  output logic                      ev_valid,
  input  logic                      ev_ready,
  output logic [REC_W-1:0]          ev_data,
  output logic [CNT_W-1:0]          raw_cnt,
  output logic [CNT_W-1:0]          war_cnt,
  output logic [CNT_W-1:0]          waw_cnt,
  output logic [CNT_W-1:0]          drop_cnt,
  output logic                      ovf
);

  localparam int AW          = $clog2(DEPTH);
  localparam int SLOT_RD_LSB = slot_rd_lsb(SLOT_W, REG_W);
  localparam int SLOT_RS_LSB = slot_rs_lsb(SLOT_W, REG_W);

  scan_state_e               state_r;
  logic [IDX_W-1:0]          idx_r;
  logic [N_SLOTS*SLOT_W-1:0] cap_r;
  logic                      push_r;
  logic [REC_W-1:0]          rec_r;

  logic [SLOT_W-1:0]         slot_s;
  hz_kind_e                  slot_kind_s;
  hz_kind_e                  rec_kind_s;
  logic                      pop_s;
  logic                      accept_s;
  logic                      fifo_full_s;
  logic                      fifo_empty_s;
  logic [AW:0]               fifo_count_s;
  logic [REC_W-1:0]          fifo_rdata_s;

  logic [CNT_W-1:0]          raw_cnt_r;
  logic [CNT_W-1:0]          war_cnt_r;
  logic [CNT_W-1:0]          waw_cnt_r;
  logic [CNT_W-1:0]          drop_cnt_r;
  logic                      ovf_r;

  // Slot under examination and kind of the staged record
  always_comb begin
    slot_s      = SLOT_W'(cap_r >> (idx_r * SLOT_W));
    slot_kind_s = hz_kind_e'(slot_s[SLOT_KIND_LSB +: KIND_W]);
    rec_kind_s  = hz_kind_e'(rec_r[REC_KIND_LSB +: KIND_W]);
  end

  // Capture/scan FSM; the staged record gives the registered enqueue stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= '0;
      cap_r   <= '0;
      push_r  <= 1'b0;
      rec_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          push_r <= 1'b0;
          if (hz_valid) begin
            cap_r   <= hz_vec;
            idx_r   <= '0;
            state_r <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          push_r <= (slot_kind_s != HZ_NONE);
          rec_r  <= {idx_r,
                     slot_s[SLOT_RD_LSB +: REG_W],
                     slot_s[SLOT_RS_LSB +: REG_W],
                     slot_kind_s};
          if (idx_r == IDX_W'(N_SLOTS - 1)) begin
            idx_r   <= '0;
            state_r <= ST_IDLE;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        default: begin
          push_r  <= 1'b0;
          idx_r   <= '0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake decode; a pop makes room for a push into a full FIFO
  always_comb begin
    pop_s    = ev_ready && !fifo_empty_s;
    accept_s = push_r && (!fifo_full_s || pop_s);
  end

  hz_sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_r),
    .pop   (pop_s),
    .wdata (rec_r),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Saturating statistics and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_cnt_r  <= '0;
      war_cnt_r  <= '0;
      waw_cnt_r  <= '0;
      drop_cnt_r <= '0;
      ovf_r      <= 1'b0;
    end else if (push_r) begin
      if (accept_s) begin
        case (rec_kind_s)
          HZ_RAW: if (raw_cnt_r != {CNT_W{1'b1}}) raw_cnt_r <= raw_cnt_r + CNT_W'(1);
          HZ_WAR: if (war_cnt_r != {CNT_W{1'b1}}) war_cnt_r <= war_cnt_r + CNT_W'(1);
          HZ_WAW: if (waw_cnt_r != {CNT_W{1'b1}}) waw_cnt_r <= waw_cnt_r + CNT_W'(1);
          default: begin
          end
        endcase
      end else begin
        if (drop_cnt_r != {CNT_W{1'b1}}) begin
          drop_cnt_r <= drop_cnt_r + CNT_W'(1);
        end
        ovf_r <= 1'b1;
      end
    end
  end

  // Head record is forced to zero while nothing is queued
  always_comb begin
    if (ev_valid) begin
      ev_data = fifo_rdata_s;
    end else begin
      ev_data = '0;
    end
  end

  assign hz_ready = (state_r == ST_IDLE);
  assign ev_valid = (fifo_count_s != '0);
  assign raw_cnt  = raw_cnt_r;
  assign war_cnt  = war_cnt_r;
  assign waw_cnt  = waw_cnt_r;
  assign drop_cnt = drop_cnt_r;
  assign ovf      = ovf_r;

endmodule
